sha256_compress_core: RTL and testbench

Self-sequencing SHA-256 compression engine: accepts 512-bit message blocks over a valid/ready handshake and chains multi-block messages. It generates its own round counter, K constants and message schedule internally, and emits a 256-bit digest after every block. It is a parametrised successor to the shared multi-mode hash datapath. It sits between the padding/block-assembly stage and the nonce-compare logic of the mining pipeline, and it performs UNROLL rounds per clock.

---
 rtl/sha256_compress_core_pkg.sv | 52 +++++
 rtl/sha256_compress_core_round.sv | 20 ++
 rtl/sha256_compress_core.sv | 123 ++++++++++++
 tb/tb_sha256_compress_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_compress_core_pkg.sv
// Shared SHA-256 definitions: IV, round constants, FSM encoding and the
// FIPS 180-4 bit-mixing functions used by the round and schedule logic.
package sha256_compress_core_pkg;

   // Eight 32-bit words; element 0 (H0 / a) sits in the MSBs.
   typedef logic [0:7][31:0] sha256_iv_t;

   localparam sha256_iv_t SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] SHA256_K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} sha256_state_e;

   // Schedule sigma0: ROTR7 ^ ROTR18 ^ SHR3
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   // Schedule sigma1: ROTR17 ^ ROTR19 ^ SHR10
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Round Sigma0: ROTR2 ^ ROTR13 ^ ROTR22
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   // Round Sigma1: ROTR6 ^ ROTR11 ^ ROTR25
   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, f, g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, b, c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_compress_core_round.sv
// One combinational SHA-256 round: a..h, W[t], K[t] -> next a..h.
module sha256_round
   import sha256_compress_core_pkg::*;
(
   input  sha256_iv_t  st,
   input  logic [31:0] w,
   input  logic [31:0] k,
   output sha256_iv_t  st_nxt
);

   logic [31:0] t1, t2;

   // T1/T2 combine, then the register file shifts down by one word
   always_comb begin
      t1     = st[7] + bsig1(st[4]) + ch(st[4], st[5], st[6]) + k + w;
      t2     = bsig0(st[0]) + maj(st[0], st[1], st[2]);
      st_nxt = {t1 + t2, st[0], st[1], st[2], st[3] + t1, st[4], st[5], st[6]};
   end

endmodule

// File: rtl/sha256_compress_core.sv
// Self-sequencing SHA-256 compression core, UNROLL rounds per clock.
// Optional feature macro: MIDSTATE_EN adds mid_use/mid_in so a first block
// can chain from a supplied midstate instead of the IV.
module sha256_compress_core
   import sha256_compress_core_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   output logic         digest_valid,
   output logic [255:0] digest
`ifdef MIDSTATE_EN
   ,
   input  logic         mid_use,
   input  logic [255:0] mid_in
`endif
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $error("sha256_compress_core: UNROLL must be 1, 2, 4 or 8");
   end

   sha256_state_e state_q, state_d;
   logic [6:0]    round_q;
   sha256_iv_t    chain_q, work_q, seed, sum, rnd_out;
   logic [31:0]   win_q [0:15];
   logic [31:0]   ext   [0:UNROLL+15];
   logic          last_step;

   assign last_step = (round_q + 7'(UNROLL)) == 7'd64;

   // Chain seed for an accepted block: IV / midstate on a first block, else running chain
   always_comb begin
      seed = chain_q;
      if (blk_first) seed = SHA256_IV;
`ifdef MIDSTATE_EN
      if (blk_first && mid_use) seed = mid_in;
`endif
   end

   // Extend the 16-word window by UNROLL words; ext[j] feeds round j of this edge
   always_comb begin
      for (int i = 0; i < 16; i++) ext[i] = win_q[i];
      for (int j = 0; j < UNROLL; j++)
         ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
   end

   // Final feed-forward add of working registers into the chain
   always_comb begin
      for (int i = 0; i < 8; i++) sum[i] = chain_q[i] + work_q[i];
   end

   // Chained rounds: each stage feeds the next within one clock
   for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
      sha256_iv_t st, nxt;
      logic [5:0] kidx;
      if (g == 0) begin : g_src
         assign st = work_q;
      end else begin : g_src
         assign st = g_rnd[g-1].nxt;
      end
      assign kidx = round_q[5:0] + 6'(g);
      sha256_round u_round (.st(st), .w(ext[g]), .k(SHA256_K[kidx]), .st_nxt(nxt));
   end
   assign rnd_out = g_rnd[UNROLL-1].nxt;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state and handshake output
   always_comb begin
      state_d   = state_q;
      blk_ready = (state_q == IDLE);
      case (state_q)
         IDLE:    if (blk_valid) state_d = ROUND;
         ROUND:   if (last_step) state_d = FINAL;
         FINAL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: window, working registers, round counter, chain and digest
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_q      <= '0;
         chain_q      <= SHA256_IV;
         work_q       <= '0;
         digest       <= '0;
         digest_valid <= 1'b0;
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else begin
         digest_valid <= 1'b0;
         case (state_q)
            IDLE: if (blk_valid) begin
               for (int i = 0; i < 16; i++) win_q[i] <= blk_data[511-32*i -: 32];
               chain_q <= seed;
               work_q  <= seed;
               round_q <= '0;
            end
            ROUND: begin
               work_q  <= rnd_out;
               round_q <= round_q + 7'(UNROLL);
               for (int i = 0; i < 16; i++) win_q[i] <= ext[i+UNROLL];
            end
            FINAL: begin
               chain_q      <= sum;
               digest       <= sum;
               digest_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_compress_core.sv
// Bench for sha256_compress_core: three instances (UNROLL 1/4/8) checked every
// cycle against a block-level SHA-256 model, plus literal digest/latency pins.
module tb_sha256_compress_core;
   import sha256_compress_core_pkg::*;

   localparam int ND = 3;
   function automatic int un_of(int i);
      return (i == 0) ? 1 : (i == 1) ? 4 : 8;
   endfunction

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] B1_BLK    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] B2_BLK    = {480'h0, 32'h000001c0};
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [255:0] IV256     = SHA256_IV;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [ND-1:0] blk_valid, blk_first, blk_ready, digest_valid;
   logic [511:0]  blk_data [ND];
   logic [255:0]  digest   [ND];
`ifdef MIDSTATE_EN
   logic [ND-1:0] mid_use;
   logic [255:0]  mid_in [ND];
`endif

   for (genvar g = 0; g < ND; g++) begin : g_dut
      sha256_compress_core #(.UNROLL(un_of(g))) dut (
         .clk(clk), .rst_n(rst_n),
         .blk_valid(blk_valid[g]), .blk_ready(blk_ready[g]),
         .blk_data(blk_data[g]), .blk_first(blk_first[g]),
         .digest_valid(digest_valid[g]), .digest(digest[g])
`ifdef MIDSTATE_EN
         , .mid_use(mid_use[g]), .mid_in(mid_in[g])
`endif
      );
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(string nm, int i, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%h required=%h", nm, i, act, exp);
      end
   endtask

   function automatic logic [31:0] rr(logic [31:0] x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straight-line FIPS 180-4 compression of one block from chaining value h
   function automatic logic [255:0] model_comp(logic [255:0] h, logic [511:0] b);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
            + SHA256_K[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
      return r;
   endfunction

   // Transaction-level model: ready/busy, pending digest due 64/U+1 edges after accept
   logic [255:0] m_chain [ND], m_dig [ND], m_pend_dig [ND];
   bit           m_ready [ND], m_vld [ND], m_pend [ND];
   int           m_due   [ND];
   int           ecnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ND; i++) begin
            m_chain[i] = IV256; m_dig[i] = '0; m_ready[i] = 1; m_vld[i] = 0; m_pend[i] = 0;
         end
      end else begin
         ecnt++;
         for (int i = 0; i < ND; i++) begin
            bit rdy_old;
            logic [255:0] sd;
            rdy_old  = m_ready[i];
            m_vld[i] = 0;
            if (m_pend[i] && ecnt == m_due[i]) begin
               m_chain[i] = m_pend_dig[i]; m_dig[i] = m_pend_dig[i];
               m_vld[i] = 1; m_pend[i] = 0; m_ready[i] = 1;
            end
            if (rdy_old && blk_valid[i]) begin
               sd = blk_first[i] ? IV256 : m_chain[i];
`ifdef MIDSTATE_EN
               if (blk_first[i] && mid_use[i]) sd = mid_in[i];
`endif
               m_pend_dig[i] = model_comp(sd, blk_data[i]);
               m_pend[i] = 1; m_ready[i] = 0;
               m_due[i] = ecnt + 64 / un_of(i) + 1;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      for (int i = 0; i < ND; i++) begin
         chk("blk_ready", i, 256'(blk_ready[i]), 256'(m_ready[i]));
         chk("digest_valid", i, 256'(digest_valid[i]), 256'(m_vld[i]));
         chk("digest", i, digest[i], m_dig[i]);
      end
   end

   task automatic send(int i, logic [511:0] d, logic f);
      int n = 0;
      @(negedge clk);
      blk_data[i] = d; blk_first[i] = f; blk_valid[i] = 1'b1;
`ifdef MIDSTATE_EN
      mid_use[i] = 1'b0;
`endif
      while (!blk_ready[i] && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) begin
         checks++; failures++;
         $display("FAIL send_timeout dut%0d actual=busy required=ready", i);
      end
      @(posedge clk); #1;
      blk_valid[i] = 1'b0; blk_data[i] = '0;
   endtask

   task automatic wait_dig(int i, int lat, logic [255:0] exp, string nm);
      int n = 0;
      bit got = 0;
      while (n < 200 && !got) begin @(posedge clk); #1; n++; got = digest_valid[i]; end
      chk({nm, "_latency"}, i, 256'(n), 256'(lat));
      chk(nm, i, digest[i], exp);
   endtask

   initial begin
      int pulses;
      logic [255:0] mid;
      blk_valid = '0; blk_first = '0;
      for (int i = 0; i < ND; i++) blk_data[i] = '0;
`ifdef MIDSTATE_EN
      mid_use = '0;
      for (int i = 0; i < ND; i++) mid_in[i] = '0;
`endif
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < ND; i++) begin
         chk("rst_digest", i, digest[i], 256'h0);
         chk("rst_ready", i, 256'(blk_ready[i]), 256'h1);
      end
      rst_n = 1'b1;

      // pin the model against published vectors
      chk("model_abc", 0, model_comp(IV256, ABC_BLK), ABC_DIG);
      chk("model_two", 0, model_comp(model_comp(IV256, B1_BLK), B2_BLK), TWO_DIG);

      send(0, ABC_BLK, 1'b1);   wait_dig(0, 65, ABC_DIG, "abc_u1");
      send(0, EMPTY_BLK, 1'b1); wait_dig(0, 65, EMPTY_DIG, "empty_u1");
      send(0, B1_BLK, 1'b1); send(0, B2_BLK, 1'b0); wait_dig(0, 65, TWO_DIG, "two_u1");
      send(1, ABC_BLK, 1'b1);   wait_dig(1, 17, ABC_DIG, "abc_u4");
      send(2, ABC_BLK, 1'b1);   wait_dig(2, 9, ABC_DIG, "abc_u8");
      send(2, B1_BLK, 1'b1); send(2, B2_BLK, 1'b0); wait_dig(2, 9, TWO_DIG, "two_u8");
      send(1, B1_BLK, 1'b1); send(1, B2_BLK, 1'b0); wait_dig(1, 17, TWO_DIG, "two_u4");

      // abort at round 30, then a blk_first=0 block must chain from the IV
      send(0, EMPTY_BLK, 1'b1);
      repeat (30) @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      pulses = 0;
      repeat (80) begin @(negedge clk); pulses += int'(digest_valid[0]); end
      chk("abort_no_digest", 0, 256'(pulses), 256'h0);
      send(0, ABC_BLK, 1'b0);   wait_dig(0, 65, ABC_DIG, "abc_after_reset");

      // valid held high through the busy period: one block only
      @(negedge clk);
      blk_data[1] = EMPTY_BLK; blk_first[1] = 1'b1; blk_valid[1] = 1'b1;
      repeat (12) @(negedge clk);
      blk_valid[1] = 1'b0;
      pulses = 0;
      repeat (40) begin @(negedge clk); pulses += int'(digest_valid[1]); end
      chk("held_valid_one_block", 1, 256'(pulses), 256'h1);
      chk("held_valid_digest", 1, digest[1], EMPTY_DIG);

`ifdef MIDSTATE_EN
      send(0, B1_BLK, 1'b1); wait_dig(0, 65, model_comp(IV256, B1_BLK), "mid_first");
      mid = digest[0];
      @(negedge clk);
      blk_data[0] = B2_BLK; blk_first[0] = 1'b1; mid_use[0] = 1'b1; mid_in[0] = mid; blk_valid[0] = 1'b1;
      @(posedge clk); #1;
      blk_valid[0] = 1'b0; mid_use[0] = 1'b0; mid_in[0] = '0;
      wait_dig(0, 65, TWO_DIG, "midstate_two");
`else
      mid = '0;
      chk("mid_unused", 0, mid, 256'h0 | digest[0] & 256'h0);
`endif

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
